// File: rtl/instr_mem_pipe.sv
// Pipelined instruction store with valid/ready request and response channels.
// Optional runtime write port enabled by defining IMEM_LOAD_EN.
module instr_mem_pipe #(
  parameter int                 DATA_W    = 32,
  parameter int                 DEPTH     = 256,
  parameter int                 ADDR_W    = 32,
  parameter int                 LAT       = 1,
  parameter logic [DATA_W-1:0]  NOP       = DATA_W'(32'h0000_0013),
  parameter string              INIT_FILE = "imem.hex",
  localparam int                IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
`ifdef IMEM_LOAD_EN
  input  logic              ld_we,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data,
`endif
  output logic              rsp_err
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [LAT-1:0]    v_q;
  logic [LAT-1:0]    e_q;
  logic [ADDR_W-1:0] a_q [LAT];
  logic [DATA_W-1:0] d_q [LAT];

  logic             out_v;
  logic             adv;
  logic             acc;
  logic             fault;
  logic [IDX_W-1:0] idx;

  assign out_v     = v_q[LAT-1];
  assign adv       = !out_v || rsp_ready;
  assign req_ready = adv && !flush && rst;
  assign acc       = req_valid && req_ready;
  assign idx       = req_addr[IDX_W+1:2];
  assign fault     = (|req_addr[1:0]) ||
                     (|(req_addr >> (IDX_W + 2)));

  // Memory and payload stages carry no reset; valids qualify them.
  always_ff @(posedge clk) begin
`ifdef IMEM_LOAD_EN
    if (rst && ld_we) mem_q[ld_idx] <= ld_data;
`endif
    if (adv) begin
      if (acc && !fault) d_q[0] <= mem_q[idx];
      a_q[0] <= req_addr;
      e_q[0] <= fault;
      for (int i = 1; i < LAT; i++) begin
        d_q[i] <= d_q[i-1];
        a_q[i] <= a_q[i-1];
        e_q[i] <= e_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      v_q <= '0;
    end else if (adv) begin
      v_q[0] <= acc;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
      end
    end
  end

  assign rsp_valid = out_v && rst;
  assign rsp_err   = rsp_valid && e_q[LAT-1];
  assign rsp_data  = (rsp_valid && !e_q[LAT-1]) ?
                     d_q[LAT-1] : NOP;
  assign rsp_addr  = rsp_valid ? a_q[LAT-1] : '0;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed bench for instr_mem_pipe: three instances with LAT=1,2,3.
// Load-port checks build only when IMEM_LOAD_EN is defined.
module tb_instr_mem_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  rv;
  logic [2:0]  rr;
  logic [2:0]  fl;
  logic [31:0] ra  [3];
  logic [2:0]  rdy;
  logic [2:0]  vo;
  logic [2:0]  eo;
  logic [31:0] rd  [3];
  logic [31:0] rao [3];
`ifdef IMEM_LOAD_EN
  logic [2:0]  we;
  logic [7:0]  li  [3];
  logic [31:0] ldd [3];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    instr_mem_pipe #(
      .DATA_W(32), .DEPTH(256), .ADDR_W(32),
      .LAT(g + 1), .NOP(32'h13), .INIT_FILE("")
    ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(rv[g]),
      .req_ready(rdy[g]),
      .req_addr(ra[g]),
      .flush(fl[g]),
      .rsp_valid(vo[g]),
      .rsp_ready(rr[g]),
      .rsp_data(rd[g]),
      .rsp_addr(rao[g]),
`ifdef IMEM_LOAD_EN
      .ld_we(we[g]),
      .ld_idx(li[g]),
      .ld_data(ldd[g]),
`endif
      .rsp_err(eo[g])
    );
    // Backdoor image: word i holds 0x1000_0000 + i.
    initial begin
      for (int i = 0; i < 256; i++)
        dut.mem_q[i] = 32'h1000_0000 + 32'(i);
    end
  end

  function automatic logic [31:0] m(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic ev;
    rv = '0;
    rr = '1;
    fl = '0;
    ra = '{default: 32'h0};
`ifdef IMEM_LOAD_EN
    we  = '0;
    li  = '{default: 8'h0};
    ldd = '{default: 32'h0};
`endif

    // reset held 3 cycles with a pending request
    rv[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rdy",  32'(rdy[1]), 32'h0);
      chk("rst_vld",  32'(vo[1]),  32'h0);
      chk("rst_data", rd[1],       32'h13);
      chk("rst_addr", rao[1],      32'h0);
    end
    rst = 1'b1;
    #1;
    chk("first_rdy", 32'(rdy[1]), 32'h1);

    // streaming on LAT=2
    for (int i = 0; i < 6; i++) begin
      tick();
      ev = (i >= 1 && i <= 4);
      chk("str_vld", 32'(vo[1]), 32'(ev));
      if (ev) begin
        chk("str_data", rd[1],  m(i - 1));
        chk("str_addr", rao[1], 32'((i - 1) * 4));
      end else begin
        chk("str_nop", rd[1], 32'h13);
      end
      rv[1] = (i + 1 <= 3);
      ra[1] = 32'((i + 1) * 4);
    end

    // backpressure on LAT=1
    rv[0] = 1'b1;
    ra[0] = 32'h10;
    tick();
    ra[0] = 32'h14;
    rr[0] = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("bp_rdy",  32'(rdy[0]), 32'h0);
      chk("bp_vld",  32'(vo[0]),  32'h1);
      chk("bp_data", rd[0],       m(4));
      chk("bp_addr", rao[0],      32'h10);
    end
    rr[0] = 1'b1;
    #1;
    chk("bp_rdy_rel", 32'(rdy[0]), 32'h1);
    tick();
    rv[0] = 1'b0;
    chk("bp_nxt_vld",  32'(vo[0]), 32'h1);
    chk("bp_nxt_data", rd[0],      m(5));
    chk("bp_nxt_addr", rao[0],     32'h14);
    tick();
    chk("bp_end_vld",  32'(vo[0]), 32'h0);
    chk("bp_end_data", rd[0],      32'h13);

    // flush on LAT=3 with three requests in flight
    rr[2] = 1'b0;
    rv[2] = 1'b1;
    ra[2] = 32'h0;
    tick();
    ra[2] = 32'h4;
    tick();
    ra[2] = 32'h8;
    tick();
    chk("fl_pre_vld", 32'(vo[2]), 32'h1);
    chk("fl_pre_dat", rd[2],      m(0));
    ra[2] = 32'h40;
    fl[2] = 1'b1;
    rr[2] = 1'b1;
    #1;
    chk("fl_rdy", 32'(rdy[2]), 32'h0);
    tick();
    fl[2] = 1'b0;
    chk("fl_vld",  32'(vo[2]), 32'h0);
    chk("fl_data", rd[2],      32'h13);
    #1;
    chk("fl_rdy_post", 32'(rdy[2]), 32'h1);
    tick();
    rv[2] = 1'b0;
    chk("fl_g0_vld", 32'(vo[2]), 32'h0);
    tick();
    chk("fl_g1_vld", 32'(vo[2]), 32'h0);
    tick();
    chk("fl_g2_vld",  32'(vo[2]), 32'h1);
    chk("fl_g2_data", rd[2],      m(16));
    chk("fl_g2_addr", rao[2],     32'h40);
    tick();
    chk("fl_g3_vld", 32'(vo[2]), 32'h0);

    // access faults on LAT=1
    rv[0] = 1'b1;
    ra[0] = 32'h2;
    tick();
    chk("flt_mis_vld",  32'(vo[0]), 32'h1);
    chk("flt_mis_err",  32'(eo[0]), 32'h1);
    chk("flt_mis_data", rd[0],      32'h13);
    chk("flt_mis_addr", rao[0],     32'h2);
    ra[0] = 32'h400;
    tick();
    chk("flt_oor_err",  32'(eo[0]), 32'h1);
    chk("flt_oor_data", rd[0],      32'h13);
    ra[0] = 32'h3FC;
    tick();
    chk("flt_top_err",  32'(eo[0]), 32'h0);
    chk("flt_top_data", rd[0],      m(255));
    chk("flt_top_addr", rao[0],     32'h3FC);
    rv[0] = 1'b0;
    tick();
    chk("flt_idle_vld", 32'(vo[0]), 32'h0);
    chk("flt_idle_err", 32'(eo[0]), 32'h0);

`ifdef IMEM_LOAD_EN
    // write and read of the same word in one cycle
    rv[0]  = 1'b1;
    ra[0]  = 32'h14;
    we[0]  = 1'b1;
    li[0]  = 8'd5;
    ldd[0] = 32'hDEAD_BEEF;
    tick();
    we[0] = 1'b0;
    chk("ld_old", rd[0], m(5));
    tick();
    rv[0] = 1'b0;
    chk("ld_new", rd[0], 32'hDEAD_BEEF);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
